// File: rtl/video_timing_pkg.sv
`default_nettype none
// ==== video_timing_pkg : mode codes, FSM encoding and timing helpers (rev 1.0) ====
package video_timing_pkg;

  localparam logic [1:0] MODE_PASS  = 2'd0;
  localparam logic [1:0] MODE_BARS  = 2'd1;
  localparam logic [1:0] MODE_GRID  = 2'd2;
  localparam logic [1:0] MODE_SOLID = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_GO = 2'd1,
    ST_RUN     = 2'd2
  } vtg_state_e;

  function automatic int vtg_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  // Per-channel on/off {R,G,B} for bars, left to right
  function automatic logic [2:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return 3'b111;
      3'd1:    return 3'b110;
      3'd2:    return 3'b011;
      3'd3:    return 3'b010;
      3'd4:    return 3'b101;
      3'd5:    return 3'b100;
      3'd6:    return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/vtg_hv_counter.sv
`default_nettype none
// ==== vtg_hv_counter : raster h/v counters with frame-wrap flag (rev 1.0) ====
module vtg_hv_counter #(
  parameter int CNT_W   = 12,
  parameter int H_TOTAL = 2200,
  parameter int V_TOTAL = 1125
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,
  output logic [CNT_W-1:0] h_o,
  output logic [CNT_W-1:0] v_o,
  output logic             frame_wrap_o
);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
  logic             h_last, v_last;

  assign h_last = (h_q == H_LAST);
  assign v_last = (v_q == V_LAST);

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (!run_i) begin
      h_d = '0;
      v_d = '0;
    end else if (h_last) begin
      h_d = '0;
      v_d = v_last ? '0 : v_q + 1'b1;
    end else begin
      h_d = h_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_o          = h_q;
  assign v_o          = v_q;
  assign frame_wrap_o = run_i & h_last & v_last;

endmodule
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
// ==== video_timing_gen : parametrised raster timing generator and output formatter (rev 1.0) ====
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int CNT_W    = 12
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iEnable,
  input  logic                  iFreeRun,
  input  logic                  iGo,
  input  logic [1:0]            ivMode,
  input  logic [3*DATA_W-1:0]   ivSolid,
  input  logic [3*DATA_W-1:0]   ivRGB,
  input  logic                  iValid,
  input  logic                  iClrUnderflow,
  output logic                  oReq,
  output logic [DATA_W-1:0]     ovR,
  output logic [DATA_W-1:0]     ovG,
  output logic [DATA_W-1:0]     ovB,
  output logic                  oHS,
  output logic                  oVS,
  output logic                  oDE,
  output logic [CNT_W-1:0]      ovHcounter,
  output logic [CNT_W-1:0]      ovVcounter,
  output logic                  oFrameStart,
  output logic                  oUnderflow
);

  localparam int PIX_W   = 3 * DATA_W;
  localparam int H_TOTAL = vtg_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = vtg_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int BAR_W   = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG_C = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END_C = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG_C = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END_C = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] BAR_W_C  = CNT_W'(BAR_W);

  vtg_state_e       state_q, state_d;
  logic             mode_load;
  logic [1:0]       mode_q;
  logic             run, frame_wrap;
  logic [CNT_W-1:0] hcnt, vcnt;

  vtg_hv_counter #(
    .CNT_W   (CNT_W),
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL)
  ) u_hv (
    .clk_i        (iClk),
    .rst_i        (iRst),
    .run_i        (run),
    .h_o          (hcnt),
    .v_o          (vcnt),
    .frame_wrap_o (frame_wrap)
  );

  assign run = (state_q == ST_RUN);

  // A stop request is only honoured at the frame wrap, so frames are never cut short
  always_comb begin
    state_d   = state_q;
    mode_load = 1'b0;
    case (state_q)
      ST_IDLE:    if (iEnable) state_d = ST_WAIT_GO;
      ST_WAIT_GO: begin
        if (!iEnable) begin
          state_d = ST_IDLE;
        end else if (iFreeRun || iGo) begin
          state_d   = ST_RUN;
          mode_load = 1'b1;
        end
      end
      ST_RUN: begin
        if (frame_wrap) begin
          mode_load = 1'b1;
          if (!iEnable) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_PASS;
    end else begin
      state_q <= state_d;
      if (mode_load) mode_q <= ivMode;
    end
  end

  logic             active, hs_win, vs_win;
  logic [CNT_W-1:0] bar_div;
  logic [2:0]       bar_idx, bar_on;
  logic [PIX_W-1:0] pat_d;

  assign active  = run && (hcnt < H_ACT_C) && (vcnt < V_ACT_C);
  assign hs_win  = run && (hcnt >= HS_BEG_C) && (hcnt < HS_END_C);
  assign vs_win  = run && (vcnt >= VS_BEG_C) && (vcnt < VS_END_C);
  assign bar_div = hcnt / BAR_W_C;
  assign bar_idx = (bar_div > CNT_W'(7)) ? 3'd7 : bar_div[2:0];
  assign bar_on  = bar_colour(bar_idx);

  always_comb begin
    pat_d = '0;
    case (mode_q)
      MODE_BARS:  pat_d = {{DATA_W{bar_on[2]}}, {DATA_W{bar_on[1]}}, {DATA_W{bar_on[0]}}};
      MODE_GRID:  pat_d = ((hcnt[4:0] == 5'd0) || (vcnt[4:0] == 5'd0)) ? '1 : '0;
      MODE_SOLID: pat_d = ivSolid;
      default:    pat_d = '0;
    endcase
  end

  logic             req_q, de1_q, hs1_q, vs1_q;
  logic [PIX_W-1:0] pat1_q;
  logic             de_q, hs_q, vs_q, unf_q;
  logic [PIX_W-1:0] rgb_q;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      req_q  <= 1'b0;
      de1_q  <= 1'b0;
      hs1_q  <= ~HS_POL;
      vs1_q  <= ~VS_POL;
      pat1_q <= '0;
      de_q   <= 1'b0;
      hs_q   <= ~HS_POL;
      vs_q   <= ~VS_POL;
      rgb_q  <= '0;
      unf_q  <= 1'b0;
    end else begin
      req_q  <= active && (mode_q == MODE_PASS);
      de1_q  <= active;
      hs1_q  <= hs_win ? HS_POL : ~HS_POL;
      vs1_q  <= vs_win ? VS_POL : ~VS_POL;
      pat1_q <= active ? pat_d : '0;
      de_q   <= de1_q;
      hs_q   <= hs1_q;
      vs_q   <= vs1_q;
      // Passthrough pixels come from the upstream FIFO; a missing word blanks the pixel
      if (!de1_q)     rgb_q <= '0;
      else if (req_q) rgb_q <= iValid ? ivRGB : '0;
      else            rgb_q <= pat1_q;
      if (req_q && !iValid) unf_q <= 1'b1;
      else if (iClrUnderflow) unf_q <= 1'b0;
    end
  end

  assign oReq        = req_q;
  assign oDE         = de_q;
  assign oHS         = hs_q;
  assign oVS         = vs_q;
  assign ovR         = rgb_q[PIX_W-1 -: DATA_W];
  assign ovG         = rgb_q[2*DATA_W-1 -: DATA_W];
  assign ovB         = rgb_q[DATA_W-1:0];
  assign ovHcounter  = hcnt;
  assign ovVcounter  = vcnt;
  assign oFrameStart = run && (hcnt == '0) && (vcnt == '0);
  assign oUnderflow  = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// ==== tb_video_timing_gen : directed self-checking bench, small 24x8 raster (rev 1.0) ====
module tb_video_timing_gen;

  logic        iClk = 1'b0;
  logic        iRst, iEnable, iFreeRun, iGo, iValid, iClrUnderflow;
  logic [1:0]  ivMode;
  logic [23:0] ivSolid, ivRGB;
  logic        oReq, oHS, oVS, oDE, oFrameStart, oUnderflow;
  logic [7:0]  ovR, ovG, ovB;
  logic [11:0] ovHcounter, ovVcounter;

  int checks = 0;
  int errors = 0;

  always #5 iClk = ~iClk;

  video_timing_gen #(
    .DATA_W(8), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(12)
  ) dut (
    .iClk(iClk), .iRst(iRst), .iEnable(iEnable), .iFreeRun(iFreeRun), .iGo(iGo),
    .ivMode(ivMode), .ivSolid(ivSolid), .ivRGB(ivRGB), .iValid(iValid),
    .iClrUnderflow(iClrUnderflow), .oReq(oReq), .ovR(ovR), .ovG(ovG), .ovB(ovB),
    .oHS(oHS), .oVS(oVS), .oDE(oDE), .ovHcounter(ovHcounter), .ovVcounter(ovVcounter),
    .oFrameStart(oFrameStart), .oUnderflow(oUnderflow)
  );

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic chk(input string tag, input int n, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s n=%0d observed=%0h expected=%0h", tag, n, obs, exp);
    end
  endtask

  // Stimulus schedule, indexed by cycle n counted from the first RUN cycle
  function automatic bit valid_in(int n);  return !(n == 222 || n == 244); endfunction
  function automatic bit clr_in(int n);    return (n == 230 || n == 244 || n == 260); endfunction
  function automatic logic [1:0] mode_in(int n);
    if (n < 300) return 2'd0;
    if (n < 450) return 2'd1;
    if (n < 586) return 2'd3;
    return 2'd2;
  endfunction

  // Expected raster: 24 clocks/line, 8 lines/frame, five frames then IDLE
  function automatic bit in_run(int p); return (p >= 0) && (p < 960); endfunction
  function automatic int hp(int p); return p % 24; endfunction
  function automatic int vp(int p); return (p / 24) % 8; endfunction
  function automatic bit act(int p); return in_run(p) && hp(p) < 16 && vp(p) < 4; endfunction
  function automatic int fmode(int p);
    case (p / 192)
      0, 1:    return 0;
      2:       return 1;
      3:       return 3;
      default: return 2;
    endcase
  endfunction
  function automatic logic [23:0] bar_exp(int idx);
    case (idx)
      0: return 24'hFFFFFF;  1: return 24'hFFFF00;  2: return 24'h00FFFF;  3: return 24'h00FF00;
      4: return 24'hFF00FF;  5: return 24'hFF0000;  6: return 24'h0000FF;  default: return 24'h000000;
    endcase
  endfunction
  function automatic logic [23:0] pat(int p);
    case (fmode(p))
      1:       return bar_exp((hp(p) / 2 > 7) ? 7 : hp(p) / 2);
      2:       return (hp(p) % 32 == 0 || vp(p) % 32 == 0) ? 24'hFFFFFF : 24'h000000;
      3:       return 24'h0A0B0C;
      default: return 24'h000000;
    endcase
  endfunction

  initial begin
    int ue;
    logic [23:0] rgb_e;
    iRst = 1'b1; iEnable = 1'b0; iFreeRun = 1'b0; iGo = 1'b0; iValid = 1'b0;
    iClrUnderflow = 1'b0; ivMode = 2'd0; ivSolid = 24'h0A0B0C; ivRGB = 24'h0;
    tick(); tick();
    chk("rst_hs", 0, oHS, 0);
    chk("rst_vs", 0, oVS, 0);
    chk("rst_de_req", 0, {oDE, oReq, oFrameStart, oUnderflow}, 0);
    chk("rst_rgb", 0, {ovR, ovG, ovB}, 0);
    iRst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("idle", i, {oHS, oVS, oDE, oReq, ovR, ovG, ovB}, 0);
      chk("idle_cnt", i, {ovHcounter, ovVcounter, 7'd0, oFrameStart}, 0);
    end

    iEnable = 1'b1; ivRGB = 24'h112233; iValid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("wait_go", i, {ovHcounter, oFrameStart, oReq, oDE}, 0);
    end
    iGo = 1'b1;
    tick();
    iGo = 1'b0;

    ue = 0;
    for (int n = 0; n < 980; n++) begin
      if (n >= 1) begin
        if (act(n - 2) && fmode(n - 2) == 0 && !valid_in(n - 1)) ue = 1;
        else if (clr_in(n - 1)) ue = 0;
      end
      if (!act(n - 2))             rgb_e = 24'h0;
      else if (fmode(n - 2) == 0)  rgb_e = valid_in(n - 1) ? 24'h112233 : 24'h0;
      else                         rgb_e = pat(n - 2);
      chk("hcnt", n, ovHcounter, in_run(n) ? hp(n) : 0);
      chk("vcnt", n, ovVcounter, in_run(n) ? vp(n) : 0);
      chk("fstart", n, oFrameStart, (in_run(n) && n % 192 == 0) ? 1 : 0);
      chk("req", n, oReq, (act(n - 1) && fmode(n - 1) == 0) ? 1 : 0);
      chk("de", n, oDE, act(n - 2) ? 1 : 0);
      chk("hs", n, oHS, (in_run(n - 2) && hp(n - 2) >= 18 && hp(n - 2) <= 20) ? 1 : 0);
      chk("vs", n, oVS, (in_run(n - 2) && vp(n - 2) >= 5 && vp(n - 2) <= 6) ? 1 : 0);
      chk("rgb", n, {ovR, ovG, ovB}, rgb_e);
      chk("unf", n, oUnderflow, ue);
      iValid = valid_in(n);
      iClrUnderflow = clr_in(n);
      ivMode = mode_in(n);
      iGo = (n == 100);
      iEnable = (n < 816);
      tick();
    end

    // Free-running restart with a starved FIFO, then an asynchronous reset mid-frame
    iEnable = 1'b1; iFreeRun = 1'b1; ivMode = 2'd0; iValid = 1'b0; iClrUnderflow = 1'b0; iGo = 1'b0;
    tick();
    chk("fr_wait", 0, {ovHcounter, oFrameStart}, 0);
    tick();
    chk("fr_start", 0, oFrameStart, 1);
    repeat (34) tick();
    chk("pre_rst_h", 34, ovHcounter, 10);
    chk("pre_rst_v", 34, ovVcounter, 1);
    chk("pre_rst_de_req_unf", 34, {oDE, oReq, oUnderflow}, 3'b111);
    #1 iRst = 1'b1;
    #1;
    chk("async_rst_cnt", 0, {ovHcounter, ovVcounter}, 0);
    chk("async_rst_ctl", 0, {oDE, oReq, oHS, oVS, oFrameStart, oUnderflow}, 0);
    chk("async_rst_rgb", 0, {ovR, ovG, ovB}, 0);
    tick();
    iRst = 1'b0; iFreeRun = 1'b0; iValid = 1'b1;
    repeat (10) tick();
    chk("post_rst_hold", 10, {ovHcounter, oFrameStart, oDE}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
